// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - fixed-image MIPS instruction ROM with registered read
//
// Read-only instruction store for the MIPS datapath. Holds a 64-word program
// image and returns one 32-bit word per clock, one cycle after the pc that
// selected it.
//
// Ports:
//   clk       input   1   system clock, rising edge active
//   rst       input   1   synchronous, active-high reset; forces a NOP out
//   pc        input   8   byte address of the instruction to fetch
//   instruct  output  32  registered instruction word

module instruction_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instruct
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  // Byte address to word index; the two low bits select a byte within the
  // word and are dropped, so misaligned fetches return the containing word.
  logic [IDX_WIDTH-1:0]  word_idx;
  logic [DATA_WIDTH-1:0] rom_word;

  // Power-up value is a NOP so the decoder sees a harmless word before the
  // first edge.
  logic [DATA_WIDTH-1:0] instruct_q = '0;

  assign word_idx = pc[ADDR_WIDTH-1:2];

  // Program image. Every index not listed (0x30..0xFC) decodes to NOP.
  always_comb begin
    rom_word = '0;
    case (word_idx)
      6'd0:    rom_word = 32'h2008_0005; // addi $t0,$zero,5
      6'd1:    rom_word = 32'h2009_000A; // addi $t1,$zero,10
      6'd2:    rom_word = 32'h0109_5020; // add  $t2,$t0,$t1
      6'd3:    rom_word = 32'h0128_5822; // sub  $t3,$t1,$t0
      6'd4:    rom_word = 32'h0109_6024; // and  $t4,$t0,$t1
      6'd5:    rom_word = 32'h0109_6825; // or   $t5,$t0,$t1
      6'd6:    rom_word = 32'h0109_702A; // slt  $t6,$t0,$t1
      6'd7:    rom_word = 32'hAC0A_0000; // sw   $t2,0($zero)
      6'd8:    rom_word = 32'h8C0F_0000; // lw   $t7,0($zero)
      6'd9:    rom_word = 32'h114F_0001; // beq  $t2,$t7,+1
      6'd10:   rom_word = 32'h2108_0001; // addi $t0,$t0,1
      6'd11:   rom_word = 32'h0800_0000; // j    0
      default: rom_word = '0;
    endcase
  end

  // Registered read; reset wins over the fetch and never touches the image.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruct_q <= '0;
    end else begin
      instruct_q <= rom_word;
    end
  end

  assign instruct = instruct_q;

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - scoreboard bench for instruction_memory

module tb_instruction_memory;

  logic        clk;
  logic        rst;
  logic [7:0]  pc;
  logic [31:0] instruct;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] image [12];

  instruction_memory dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .instruct (instruct)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    if (idx < 12) return image[idx];
    return 32'h0000_0000;
  endfunction

  // Inputs change half a period after an edge; the result of the following
  // edge is checked 5 time units after it.
  task automatic drive(input string tag, input logic [7:0] p, input logic r);
    logic [31:0] exp;
    pc  = p;
    rst = r;
    exp_q.push_back(r ? 32'h0000_0000 : model(p));
    @(posedge clk);
    #5;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got=%h expected=entry", tag, instruct);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, instruct, exp);
    end
  endtask

  initial begin
    image[0]  = 32'h2008_0005;
    image[1]  = 32'h2009_000A;
    image[2]  = 32'h0109_5020;
    image[3]  = 32'h0128_5822;
    image[4]  = 32'h0109_6024;
    image[5]  = 32'h0109_6825;
    image[6]  = 32'h0109_702A;
    image[7]  = 32'hAC0A_0000;
    image[8]  = 32'h8C0F_0000;
    image[9]  = 32'h114F_0001;
    image[10] = 32'h2108_0001;
    image[11] = 32'h0800_0000;

    rst = 1'b1;
    pc  = 8'h00;

    drive("reset_state", 8'h00, 1'b1);

    drive("first_fetch_a", 8'h00, 1'b0);
    drive("first_fetch_b", 8'h00, 1'b0);
    check_eq("first_fetch_dec", instruct, 32'd537395205);

    drive("rst_prio", 8'h08, 1'b1);
    drive("post_rst", 8'h08, 1'b0);

    for (int a = 0; a <= 8'h2C; a += 4) begin
      drive($sformatf("sweep_%02h", a), 8'(a), 1'b0);
    end

    drive("mis_0d", 8'h0D, 1'b0);
    drive("mis_0e", 8'h0E, 1'b0);
    drive("mis_0f", 8'h0F, 1'b0);
    check_eq("mis_0f_abs", instruct, 32'h0128_5822);

    drive("nop_30", 8'h30, 1'b0);
    drive("nop_fc", 8'hFC, 1'b0);
    drive("nop_ff", 8'hFF, 1'b0);

    // Output must hold across a mid-cycle pc change.
    drive("hold_pre", 8'h00, 1'b0);
    pc = 8'h04;
    #2;
    check_eq("hold_mid", instruct, 32'h2008_0005);
    drive("hold_post", 8'h04, 1'b0);
    drive("rst_at_04", 8'h04, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 40; i++) begin
      drive($sformatf("rand_%0d", i), 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
